bcd_serial_add_ctrl: RTL and testbench

- Sequencer that adds two DIGITS-wide packed-BCD operands by time-multiplexing one external single-digit BCD adder, one digit per clock, least significant digit first.
- Sits between a host start/done handshake and a combinational digit adder (s, cout, a, b, cin).
- Validates operands, chains the decimal carry between digits and assembles the packed result.

---
 rtl/bcd_serial_add_ctrl.sv | 160 ++++++++++++++++
 tb/tb_bcd_serial_add_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_add_ctrl.sv
// bcd_serial_add_ctrl
// Adds two packed-BCD operands one digit per clock, least significant digit
// first, by sharing a single external combinational BCD digit adder.
// Operands holding a non-BCD digit are rejected without using the adder.
// Optional macro BCD_SUB_EN adds a 'sub' input that turns the operation
// into A-B in ten's complement (nines' complement of B, carry-in forced to 1).
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4,
  parameter int IDXW   = $clog2(DIGITS) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
`ifdef BCD_SUB_EN
  input  logic                  sub,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic [3:0]            dig_a,
  output logic [3:0]            dig_b,
  output logic                  dig_cin,
  input  logic [3:0]            dig_s,
  input  logic                  dig_cout
);

  typedef enum logic [1:0] {IDLE, ADD, FIN} state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

  state_t              r_state;
  state_t              w_next;
  logic [4*DIGITS-1:0] r_a;
  logic [4*DIGITS-1:0] r_b;
  logic [4*DIGITS-1:0] r_sum;
  logic                r_carry;
  logic                r_cout;
  logic                r_err;
  logic                r_sub;
  logic [IDXW-1:0]     r_idx;
  logic                w_allBcd;
  logic                w_subReq;
  logic                w_startCarry;
  logic [3:0]          w_bDigit;

`ifdef BCD_SUB_EN
  assign w_subReq = sub;
`else
  assign w_subReq = 1'b0;
`endif

  // Subtraction starts the carry chain at 1 for the ten's complement of B
  assign w_startCarry = w_subReq | cin;

  // Every digit of both operands must be 9 or less for the operation to run
  always_comb begin
    w_allBcd = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) begin
        w_allBcd = 1'b0;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = w_allBcd ? ADD : FIN;
        end
      end
      ADD: begin
        if (r_idx == LAST_IDX) begin
          w_next = FIN;
        end
      end
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Digit adder drive: only active in ADD, otherwise held at zero
  always_comb begin
    dig_a    = 4'd0;
    dig_b    = 4'd0;
    dig_cin  = 1'b0;
    w_bDigit = r_b[4*r_idx +: 4];
    if (r_state == ADD) begin
      dig_a   = r_a[4*r_idx +: 4];
      dig_b   = r_sub ? (4'd9 - w_bDigit) : w_bDigit;
      dig_cin = r_carry;
    end
  end

  // Operand latch, digit sequencing and result assembly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_err   <= 1'b0;
      r_sub   <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_sub   <= w_subReq;
            r_carry <= w_startCarry;
            r_idx   <= '0;
            if (w_allBcd) begin
              r_err <= 1'b0;
            end else begin
              r_err  <= 1'b1;
              r_sum  <= '0;
              r_cout <= 1'b0;
            end
          end
        end
        ADD: begin
          r_sum[4*r_idx +: 4] <= dig_s;
          r_carry             <= dig_cout;
          r_idx               <= r_idx + IDXW'(1);
          if (r_idx == LAST_IDX) begin
            r_cout <= dig_cout;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (r_state == ADD);
  assign done = (r_state == FIN);
  assign err  = r_err;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// tb_bcd_serial_add_ctrl
// Directed bench for bcd_serial_add_ctrl with DIGITS=4 and a behavioural
// single-digit BCD adder. Build with BCD_SUB_EN to include subtraction cases.
module tb_bcd_serial_add_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
`ifdef BCD_SUB_EN
  logic        sub;
`endif
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] sum;
  logic        cout;
  logic [3:0]  dig_a;
  logic [3:0]  dig_b;
  logic        dig_cin;
  logic [3:0]  dig_s;
  logic        dig_cout;

  int checkCount;
  int errorCount;
  int doneCount;

  logic [3:0] expDigA [4];
  logic [3:0] expDigB [4];
  logic       expDigC [4];

  bcd_serial_add_ctrl #(.DIGITS(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
`ifdef BCD_SUB_EN
    .sub      (sub),
`endif
    .busy     (busy),
    .done     (done),
    .err      (err),
    .sum      (sum),
    .cout     (cout),
    .dig_a    (dig_a),
    .dig_b    (dig_b),
    .dig_cin  (dig_cin),
    .dig_s    (dig_s),
    .dig_cout (dig_cout)
  );

  // Clock generation, 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-digit BCD adder standing in for the external one
  logic [4:0] adderRaw;
  always_comb begin
    adderRaw = {1'b0, dig_a} + {1'b0, dig_b} + {4'd0, dig_cin};
    if (adderRaw > 5'd9) begin
      dig_s    = 4'(adderRaw - 5'd10);
      dig_cout = 1'b1;
    end else begin
      dig_s    = adderRaw[3:0];
      dig_cout = 1'b0;
    end
  end

  // Count done pulses away from the active edge
  always @(negedge clk) begin
    if (done) doneCount++;
  end

  // Compare one observed value against its expectation
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Present operands and pulse start across one rising edge
  task automatic applyStimulus(input logic [15:0] opA, input logic [15:0] opB, input logic opCin);
    a     = opA;
    b     = opB;
    cin   = opCin;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Wait for done with a cycle budget and check how many edges it took
  task automatic waitDone(input string tag, input int expEdges);
    int n;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({tag, "_latency"}, 64'(n), 64'(expEdges));
  endtask

  // Full operation with result, pulse width and err hold checks
  task automatic runOp(input string tag, input logic [15:0] opA, input logic [15:0] opB,
                       input logic opCin, input logic [15:0] expSum, input logic expCout,
                       input logic expErr);
    applyStimulus(opA, opB, opCin);
    waitDone(tag, expErr ? 0 : 4);
    checkOutput({tag, "_sum"},  64'(sum),  64'(expSum));
    checkOutput({tag, "_cout"}, 64'(cout), 64'(expCout));
    checkOutput({tag, "_err"},  64'(err),  64'(expErr));
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_dig"},  64'({dig_a, dig_b, dig_cin}), 64'd0);
    @(posedge clk);
    #1;
    checkOutput({tag, "_donefall"}, 64'(done), 64'd0);
    checkOutput({tag, "_errhold"},  64'(err),  64'(expErr));
    checkOutput({tag, "_sumhold"},  64'(sum),  64'(expSum));
  endtask

  initial begin
    int baseDone;
    checkCount = 0;
    errorCount = 0;
    doneCount  = 0;
    expDigA = '{4'd4, 4'd3, 4'd2, 4'd1};
    expDigB = '{4'd8, 4'd7, 4'd6, 4'd5};
    expDigC = '{1'b0, 1'b1, 1'b1, 1'b0};
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
`ifdef BCD_SUB_EN
    sub   = 1'b0;
`endif

    // Reset state
    #12;
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_err",  64'(err),  64'd0);
    checkOutput("rst_sum",  64'(sum),  64'd0);
    checkOutput("rst_cout", 64'(cout), 64'd0);
    checkOutput("rst_dig",  64'({dig_a, dig_b, dig_cin}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Digit stepping for 1234 + 5678
    applyStimulus(16'h1234, 16'h5678, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("step%0d_busy", i), 64'(busy),    64'd1);
      checkOutput($sformatf("step%0d_a", i),    64'(dig_a),   64'(expDigA[i]));
      checkOutput($sformatf("step%0d_b", i),    64'(dig_b),   64'(expDigB[i]));
      checkOutput($sformatf("step%0d_cin", i),  64'(dig_cin), 64'(expDigC[i]));
      @(posedge clk);
      #1;
    end
    checkOutput("step_done", 64'(done), 64'd1);
    checkOutput("step_sum",  64'(sum),  64'h6912);
    checkOutput("step_cout", 64'(cout), 64'd0);
    checkOutput("step_err",  64'(err),  64'd0);
    @(posedge clk);
    #1;
    checkOutput("step_donefall", 64'(done), 64'd0);

    // Wrap-around and carry-in propagation
    runOp("wrap",  16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    runOp("cinup", 16'h0999, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0);
    runOp("mix",   16'h0758, 16'h0467, 1'b0, 16'h1225, 1'b0, 1'b0);

    // Rejected operand, then a valid one clears err
    runOp("reject",  16'h12A4, 16'h0003, 1'b0, 16'h0000, 1'b0, 1'b1);
    runOp("rejectb", 16'h0001, 16'hF000, 1'b0, 16'h0000, 1'b0, 1'b1);
    runOp("recover", 16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0);

    // Start pulse during ADD is ignored and a changing 'a' has no effect
    baseDone = doneCount;
    applyStimulus(16'h1111, 16'h2222, 1'b0);
    @(posedge clk);
    #1;
    a     = 16'h9999;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone("ignore", 2);
    checkOutput("ignore_sum", 64'(sum), 64'h3333);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checkOutput("ignore_pulses", 64'(doneCount - baseDone), 64'd1);
    checkOutput("ignore_idle",   64'(busy), 64'd0);

    // Reset mid-operation aborts without a done pulse
    baseDone = doneCount;
    applyStimulus(16'h4444, 16'h4444, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checkOutput("abort_prebusy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_sum",  64'(sum),  64'd0);
    checkOutput("abort_cout", 64'(cout), 64'd0);
    checkOutput("abort_dig",  64'({dig_a, dig_b, dig_cin}), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abort_nodone", 64'(doneCount - baseDone), 64'd0);
    runOp("after", 16'h4444, 16'h4444, 1'b0, 16'h8888, 1'b0, 1'b0);

`ifdef BCD_SUB_EN
    // Ten's complement subtraction; cin is ignored when subtracting
    sub = 1'b1;
    runOp("subpos", 16'h5000, 16'h1234, 1'b0, 16'h3766, 1'b1, 1'b0);
    runOp("subneg", 16'h1234, 16'h5000, 1'b1, 16'h6234, 1'b0, 1'b0);
    sub = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
